// File: rtl/pipelined_datapath.sv
// rtl/pipelined_datapath.sv - two-stage (E/M) pipelined MIPS-style datapath
// Register file, operand forwarding, load-use and memory-wait stalls.
module pipelined_datapath #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int IMM_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_dst,
  input  logic                  alu_src,
  input  logic                  imm_signed,
  input  logic [3:0]            alu_op,
  input  logic [4:0]            shamt,
  input  logic [IMM_WIDTH-1:0]  immediate,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] data_address,
  output logic [DATA_WIDTH-1:0] data_writedata,
  output logic                  data_read,
  output logic                  data_write,
  input  logic                  data_waitrequest,
  input  logic [DATA_WIDTH-1:0] data_readdata,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] register_v0
);

  localparam int NREGS = 1 << REG_ADDR_W;
  localparam int EXT_W = DATA_WIDTH - IMM_WIDTH;

  logic [DATA_WIDTH-1:0] regs [NREGS];
  logic                  started;

  logic                  e_valid, e_mem_read, e_mem_write, e_reg_write;
  logic [REG_ADDR_W-1:0] e_dest;
  logic [3:0]            e_alu_op;
  logic [4:0]            e_shamt;
  logic [IMM_WIDTH-1:0]  e_imm;
  logic [DATA_WIDTH-1:0] e_op1, e_op2, e_store, e_result;

  logic                  m_valid, m_mem_read, m_mem_write, m_reg_write;
  logic [REG_ADDR_W-1:0] m_dest;
  logic [DATA_WIDTH-1:0] m_result, m_store;

  logic                  m_hold, m_complete, e_advance, accept;
  logic [DATA_WIDTH-1:0] ext_imm;

  assign m_hold     = m_valid && (m_mem_read || m_mem_write) && data_waitrequest;
  assign m_complete = m_valid && !m_hold;
  assign e_advance  = !m_hold;

  always_comb begin
    e_result = '0;
    case (e_alu_op)
      4'd0:  e_result = e_op1 + e_op2;
      4'd1:  e_result = e_op1 - e_op2;
      4'd2:  e_result = e_op1 & e_op2;
      4'd3:  e_result = e_op1 | e_op2;
      4'd4:  e_result = e_op1 ^ e_op2;
      4'd5:  e_result = ~(e_op1 | e_op2);
      4'd6:  e_result = {{(DATA_WIDTH-1){1'b0}}, $signed(e_op1) < $signed(e_op2)};
      4'd7:  e_result = {{(DATA_WIDTH-1){1'b0}}, e_op1 < e_op2};
      4'd8:  e_result = e_op2 << e_shamt;
      4'd9:  e_result = e_op2 >> e_shamt;
      4'd10: e_result = $unsigned($signed(e_op2) >>> e_shamt);
      4'd11: e_result = {e_imm, {EXT_W{1'b0}}};
      default: e_result = '0;
    endcase
  end

  typedef struct packed {
    logic                  stall;
    logic [DATA_WIDTH-1:0] value;
  } operand_t;

  // Youngest producer wins; an unresolved load result forces a stall.
  function automatic operand_t resolve(input logic [REG_ADDR_W-1:0] idx);
    operand_t r;
    r.stall = 1'b0;
    r.value = regs[idx];
    if (idx == '0) begin
      r.value = '0;
    end else if (e_valid && e_reg_write && !e_mem_read && e_dest == idx) begin
      r.value = e_result;
    end else if (e_valid && e_mem_read && e_dest == idx) begin
      r.stall = 1'b1;
    end else if (m_valid && m_reg_write && m_dest == idx) begin
      if (!m_mem_read)     r.value = m_result;
      else if (m_complete) r.value = data_readdata;
      else                 r.stall = 1'b1;
    end
    return r;
  endfunction

  operand_t op_rs, op_rt;

  always_comb begin
    op_rs = resolve(rs);
    op_rt = resolve(rt);
  end

  assign ext_imm  = imm_signed ? {{EXT_W{immediate[IMM_WIDTH-1]}}, immediate}
                               : {{EXT_W{1'b0}}, immediate};
  assign in_ready = started && !op_rs.stall && !op_rt.stall && !(e_valid && m_hold);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      started     <= 1'b0;
      e_valid     <= 1'b0;
      e_mem_read  <= 1'b0;
      e_mem_write <= 1'b0;
      e_reg_write <= 1'b0;
      e_dest      <= '0;
      e_alu_op    <= '0;
      e_shamt     <= '0;
      e_imm       <= '0;
      e_op1       <= '0;
      e_op2       <= '0;
      e_store     <= '0;
      m_valid     <= 1'b0;
      m_mem_read  <= 1'b0;
      m_mem_write <= 1'b0;
      m_reg_write <= 1'b0;
      m_dest      <= '0;
      m_result    <= '0;
      m_store     <= '0;
    end else begin
      started <= 1'b1;
      if (e_advance) begin
        m_valid     <= e_valid;
        m_mem_read  <= e_mem_read;
        m_mem_write <= e_mem_write;
        m_reg_write <= e_reg_write;
        m_dest      <= e_dest;
        m_result    <= e_result;
        m_store     <= e_store;
      end
      if (accept) begin
        e_valid     <= 1'b1;
        e_mem_read  <= mem_read;
        e_mem_write <= mem_write;
        e_reg_write <= reg_write;
        e_dest      <= reg_dst ? rd : rt;
        e_alu_op    <= alu_op;
        e_shamt     <= shamt;
        e_imm       <= immediate;
        e_op1       <= op_rs.value;
        e_op2       <= alu_src ? ext_imm : op_rt.value;
        e_store     <= op_rt.value;
      end else if (e_advance) begin
        e_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[m_dest] <= wb_data;
    end
  end

  assign data_read      = m_valid && m_mem_read;
  assign data_write     = m_valid && m_mem_write;
  assign data_address   = m_result;
  assign data_writedata = m_store;
  assign wb_valid       = m_complete && m_reg_write && (m_dest != '0);
  assign wb_addr        = m_dest;
  assign wb_data        = m_mem_read ? data_readdata : m_result;
  assign register_v0    = regs[2];

endmodule

// File: tb/tb_pipelined_datapath.sv
// tb/tb_pipelined_datapath.sv - directed and randomized checks against an instruction-level model
module tb_pipelined_datapath;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk;
  logic          reset;
  logic          in_valid, in_ready;
  logic [AW-1:0] rs, rt, rd;
  logic          reg_dst, alu_src, imm_signed;
  logic [3:0]    alu_op;
  logic [4:0]    shamt;
  logic [IW-1:0] immediate;
  logic          mem_read, mem_write, reg_write;
  logic [DW-1:0] data_address, data_writedata, data_readdata;
  logic          data_read, data_write, data_waitrequest;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data, register_v0;

  pipelined_datapath #(.DATA_WIDTH(DW), .REG_ADDR_W(AW), .IMM_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst), .alu_src(alu_src),
    .imm_signed(imm_signed), .alu_op(alu_op), .shamt(shamt), .immediate(immediate),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_read(data_read), .data_write(data_write),
    .data_waitrequest(data_waitrequest), .data_readdata(data_readdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .register_v0(register_v0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [4:0]  rs, rt, rd;
    logic        reg_dst, alu_src, imm_signed;
    logic [3:0]  op;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        mr, mw, rw;
  } instr_t;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_regs [32];
  logic [DW-1:0] seen_wb  [32];
  logic [DW-1:0] ref_mem [logic [DW-1:0]];
  logic [DW-1:0] bus_mem [logic [DW-1:0]];
  logic [AW+DW-1:0] exp_wb [$];
  logic [2*DW-1:0]  exp_st [$];
  bit rand_wait = 1'b0;
  int wait_left = 0;

  function automatic logic [DW-1:0] mem_init(input logic [DW-1:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                                input logic [4:0] d, input logic rdst, input logic src,
                                input logic sgn, input logic [15:0] imm, input logic [4:0] sh,
                                input logic mr, input logic mw, input logic rw);
    instr_t i;
    i.op = op; i.rs = s; i.rt = t; i.rd = d; i.reg_dst = rdst; i.alu_src = src;
    i.imm_signed = sgn; i.imm = imm; i.sh = sh; i.mr = mr; i.mw = mw; i.rw = rw;
    return i;
  endfunction

  // Architectural execution in program order
  function automatic void model_exec(input instr_t ins);
    logic [DW-1:0] a, b, ext, op2, res, val;
    logic [AW-1:0] d;
    a   = ref_regs[ins.rs];
    b   = ref_regs[ins.rt];
    ext = {16'h0000, ins.imm};
    if (ins.imm_signed && ins.imm[15]) ext = ext + 32'hFFFF_0000;
    op2 = ins.alu_src ? ext : b;
    case (ins.op)
      4'd0:  res = a + op2;
      4'd1:  res = a - op2;
      4'd2:  res = a & op2;
      4'd3:  res = a | op2;
      4'd4:  res = a ^ op2;
      4'd5:  res = ~(a | op2);
      4'd6:  res = ((a ^ 32'h8000_0000) < (op2 ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      4'd7:  res = (a < op2) ? 32'd1 : 32'd0;
      4'd8:  res = op2 << ins.sh;
      4'd9:  res = op2 >> ins.sh;
      4'd10: begin
        res = op2 >> ins.sh;
        if (op2[31]) res = res | ~(32'hFFFF_FFFF >> ins.sh);
      end
      4'd11: res = {ins.imm, 16'h0000};
      default: res = 32'd0;
    endcase
    val = res;
    if (ins.mr) val = ref_mem.exists(res) ? ref_mem[res] : mem_init(res);
    if (ins.mw) begin
      ref_mem[res] = b;
      exp_st.push_back({res, b});
    end
    d = ins.reg_dst ? ins.rd : ins.rt;
    if (ins.rw && d != 5'd0) begin
      ref_regs[d] = val;
      exp_wb.push_back({d, val});
    end
  endfunction

  task automatic drive(input instr_t ins);
    rs = ins.rs; rt = ins.rt; rd = ins.rd; reg_dst = ins.reg_dst; alu_src = ins.alu_src;
    imm_signed = ins.imm_signed; alu_op = ins.op; shamt = ins.sh; immediate = ins.imm;
    mem_read = ins.mr; mem_write = ins.mw; reg_write = ins.rw;
  endtask

  task automatic issue(input instr_t ins, output int stalls);
    int n;
    n = 0;
    @(negedge clk);
    drive(ins);
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    stalls = n;
    if (in_ready) begin
      model_exec(ins);
      @(posedge clk);
      #1;
    end else begin
      chk("issue_ready_timeout", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_wb.size() != 0 || exp_st.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_wb_pending", 64'(exp_wb.size()), 64'd0);
    chk("drain_store_pending", 64'(exp_st.size()), 64'd0);
  endtask

  // Memory bus: wait states and read data change just after the rising edge
  initial begin : bus_driver
    data_waitrequest = 1'b0;
    data_readdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_wait)
        data_waitrequest = (data_read || data_write) && ($urandom_range(0, 2) == 0);
      else if (wait_left > 0 && (data_read || data_write)) begin
        data_waitrequest = 1'b1;
        wait_left--;
      end else
        data_waitrequest = 1'b0;
      data_readdata = bus_mem.exists(data_address) ? bus_mem[data_address] : mem_init(data_address);
    end
  end

  initial begin : monitor
    logic [AW+DW-1:0] w;
    logic [2*DW-1:0]  s;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (wb_valid) begin
          chk("wb_expected", 64'(exp_wb.size() != 0), 64'd1);
          if (exp_wb.size() != 0) begin
            w = exp_wb.pop_front();
            chk("wb_addr_data", 64'({wb_addr, wb_data}), 64'(w));
          end
          seen_wb[wb_addr] = wb_data;
        end
        if (data_write && !data_waitrequest) begin
          chk("store_expected", 64'(exp_st.size() != 0), 64'd1);
          if (exp_st.size() != 0) begin
            s = exp_st.pop_front();
            chk("store_addr_data", {data_address, data_writedata}, s);
          end
          bus_mem[data_address] = data_writedata;
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int     s;
    instr_t ins;
    logic   exp_dw [5];
    logic   exp_rdy [5];
    exp_dw  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 32; i++) begin
      ref_regs[i] = '0;
      seen_wb[i]  = 32'hDEAD_BEEF;
    end

    reset = 1'b1;
    drive(mk(4'd0, 5'd0, 5'd6, 5'd0, 1'b0, 1'b1, 1'b1, 16'h1234, 5'd0, 1'b0, 1'b0, 1'b1));
    in_valid = 1'b1;
    #3 reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    chk("reset_data_read", 64'(data_read), 64'd0);
    chk("reset_data_write", 64'(data_write), 64'd0);
    chk("reset_register_v0", 64'(register_v0), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    in_valid = 1'b0;
    #1 chk("ready_before_first_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 chk("ready_after_first_edge", 64'(in_ready), 64'd1);

    issue(mk(4'd0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1), s);
    chk("first_accept_stalls", 64'(s), 64'd0);
    issue(mk(4'd0, 5'd2, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0005, 5'd0, 1'b0, 1'b0, 1'b1), s);
    chk("e_forward_stalls", 64'(s), 64'd0);
    chk("v0_before_first_wb", 64'(register_v0), 64'd0);
    @(posedge clk);
    #1 chk("v0_first_addi", 64'(register_v0), 64'hFFFF_FFFF);
    @(posedge clk);
    #1 chk("v0_forwarded_addi", 64'(register_v0), 64'h0000_0004);

    issue(mk(4'd3, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1), s);

    bus_mem[32'h10] = 32'h1234_5678;
    ref_mem[32'h10] = 32'h1234_5678;
    issue(mk(4'd0, 5'd0, 5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0010, 5'd0, 1'b1, 1'b0, 1'b1), s);
    issue(mk(4'd0, 5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    chk("load_use_stall_cycles", 64'(s), 64'd1);
    drain();

    wait_left = 3;
    issue(mk(4'd0, 5'd0, 5'd2, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0020, 5'd0, 1'b0, 1'b1, 1'b0), s);
    issue(mk(4'd0, 5'd2, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    chk("store_follower_stalls", 64'(s), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("memwait_data_write_%0d", k), 64'(data_write), 64'(exp_dw[k]));
      chk($sformatf("memwait_in_ready_%0d", k), 64'(in_ready), 64'(exp_rdy[k]));
      if (k < 4) chk($sformatf("memwait_address_%0d", k), 64'(data_address), 64'h20);
    end

    issue(mk(4'd0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 5'd0, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 16'h0001, 5'd0, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd6, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd7, 5'd8, 5'd9, 5'd11, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd11, 5'd0, 5'd12, 5'd0, 1'b0, 1'b1, 1'b0, 16'h8000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd10, 5'd0, 5'd12, 5'd13, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd4, 1'b0, 1'b0, 1'b1), s);
    issue(mk(4'd0, 5'd8, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b1), s);
    drain();
    chk("zext_or_r3", 64'(seen_wb[3]), 64'h0000_FFFF);
    chk("load_use_r5", 64'(seen_wb[5]), 64'h2468_ACF0);
    chk("store_follower_r7", 64'(seen_wb[7]), 64'h0000_0008);
    chk("slt_r10", 64'(seen_wb[10]), 64'd1);
    chk("sltu_r11", 64'(seen_wb[11]), 64'd0);
    chk("lui_r12", 64'(seen_wb[12]), 64'h8000_0000);
    chk("sra_r13", 64'(seen_wb[13]), 64'hF800_0000);

    rand_wait = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int cls;
      cls = $urandom_range(0, 9);
      ins.rs = 5'($urandom_range(0, 7));
      ins.rt = 5'($urandom_range(0, 7));
      ins.rd = 5'($urandom_range(0, 7));
      ins.reg_dst = 1'($urandom_range(0, 1));
      ins.alu_src = 1'($urandom_range(0, 1));
      ins.imm_signed = 1'($urandom_range(0, 1));
      ins.op = 4'($urandom_range(0, 15));
      ins.sh = 5'($urandom_range(0, 31));
      ins.imm = 16'($urandom);
      ins.mr = (cls <= 1);
      ins.mw = (cls == 2);
      ins.rw = (cls != 2) && (cls != 9);
      issue(ins, s);
      if ($urandom_range(0, 4) == 0) @(posedge clk);
    end
    rand_wait = 1'b0;
    drain();
    chk("v0_final", 64'(register_v0), 64'(ref_regs[2]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
